// File: rtl/pcie_ram_pkg.sv
// Shared types and sizes for the PCIe DMA TS RAM write/read paths.
// Pure definitions, no timing or backpressure of its own.
package pcie_ram_pkg;

  localparam int DMA_DATA_W     = 64;
  localparam int RAM_DATA_W     = 512;
  localparam int BEATS_PER_WORD = 8;
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } wr_state_t;

  // Byte 0 of the PCIe beat moves to bits [7:0].
  function automatic logic [DMA_DATA_W-1:0] bswap64(input logic [DMA_DATA_W-1:0] d);
    logic [DMA_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DMA_DATA_W / 8; i++) begin
      r[8*i +: 8] = d[DMA_DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_wr_ram_if.sv
// DMA write-side bus into pcie_wr_ram plus its TS RAM port-A and status outputs.
// Master is the DMA/test side, slave is the RAM writer; no flow control beyond dma_wdata_busy.
interface pcie_wr_ram_if
  import pcie_ram_pkg::*;
#(
  parameter int ADDR_W = 11
);

  logic                  dma_waddr_en;
  logic [31:0]           dma_waddr;
  logic                  dma_wdata_en;
  logic [DMA_DATA_W-1:0] dma_wdata;
  logic                  dma_wdata_busy;
  logic                  ram_wea;
  logic [ADDR_W-1:0]     ram_addra;
  logic [RAM_DATA_W-1:0] ram_dina;
  logic                  ts_ram_valid;
  logic                  ts_ram_clear;
  logic [15:0]           drop_cnt;

  modport master (
    output dma_waddr_en, dma_waddr, dma_wdata_en, dma_wdata, ts_ram_clear,
    input  dma_wdata_busy, ram_wea, ram_addra, ram_dina, ts_ram_valid, drop_cnt
  );

  modport slave (
    input  dma_waddr_en, dma_waddr, dma_wdata_en, dma_wdata, ts_ram_clear,
    output dma_wdata_busy, ram_wea, ram_addra, ram_dina, ts_ram_valid, drop_cnt
  );

endinterface

// File: rtl/pcie_wr_pack.sv
// 64->512 MSB-first lane packer; beat k lands in lane k, word visible the cycle after the beat.
// No backpressure: every i_vld beat is taken. PCIE_WR_BYTESWAP_EN byte-reverses each beat.
module pcie_wr_pack
  import pcie_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_vld,
  input  logic [DMA_DATA_W-1:0] i_dat,
  output logic [RAM_DATA_W-1:0] o_word,
  output logic                  o_last
);

  logic [BEAT_CNT_W-1:0] r_cnt;
  logic [RAM_DATA_W-1:0] r_word;
  logic [DMA_DATA_W-1:0] w_beat;

`ifdef PCIE_WR_BYTESWAP_EN
  assign w_beat = bswap64(i_dat);
`else
  assign w_beat = i_dat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_vld) begin
      for (int k = 0; k < BEATS_PER_WORD; k++) begin
        if (r_cnt == BEAT_CNT_W'(k)) begin
          r_word[RAM_DATA_W-1-DMA_DATA_W*k -: DMA_DATA_W] <= w_beat;
        end
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_cnt == BEAT_CNT_W'(BEATS_PER_WORD-1));

endmodule

// File: rtl/pcie_wr_ram.sv
// DMA address + 8 beats -> one 512-bit TS RAM port-A write (wea one cycle after 8th beat), frame flag.
// Backpressure: dma_wdata_busy high outside IDLE; beats outside COLLECT are dropped and counted.
module pcie_wr_ram
  import pcie_ram_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int FRAME_WORDS = 64
)(
  input  logic              clk,
  input  logic              rst,
  pcie_wr_ram_if.slave      bus
);

  localparam int FCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wea;
  logic              r_busy;
  logic              r_valid;
  logic [15:0]       r_drop;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_start;
  logic w_beat_vld;
  logic w_drop;
  logic w_last;
  logic w_frame_end;
  logic w_unused_addr;

  assign w_start     = bus.dma_waddr_en && (r_state == ST_IDLE);
  assign w_beat_vld  = bus.dma_wdata_en && (r_state == ST_COLLECT);
  assign w_drop      = bus.dma_wdata_en && (r_state != ST_COLLECT);
  assign w_frame_end = (r_frame_cnt == FCNT_W'(FRAME_WORDS-1));
  assign w_unused_addr = ^{bus.dma_waddr[31:ADDR_W+6], bus.dma_waddr[5:0]};

  pcie_wr_pack u_pack (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_vld  (w_beat_vld),
    .i_dat  (bus.dma_wdata),
    .o_word (bus.ram_dina),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wea   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr  <= bus.dma_waddr[ADDR_W+5:6];
            r_busy  <= 1'b1;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_beat_vld && w_last) begin
            r_wea   <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A frame-completing write beats a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (r_state == ST_WRITE) begin
        r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + 1'b1;
      end
      if ((r_state == ST_WRITE) && w_frame_end) begin
        r_valid <= 1'b1;
      end else if (bus.ts_ram_clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.dma_wdata_busy = r_busy;
  assign bus.ram_wea        = r_wea;
  assign bus.ram_addra      = r_addr;
  assign bus.ts_ram_valid   = r_valid;
  assign bus.drop_cnt       = r_drop;

endmodule

// File: tb/tb_pcie_wr_ram.sv
// Scoreboard bench for pcie_wr_ram: expected RAM writes are queued at stimulus time and
// matched against every ram_wea pulse; status outputs are compared at fixed points.
module tb_pcie_wr_ram;
  import pcie_ram_pkg::*;

  localparam int ADDR_W      = 11;
  localparam int FRAME_WORDS = 64;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [RAM_DATA_W-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_wr_ram_if #(.ADDR_W(ADDR_W)) bus ();

  pcie_wr_ram #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  wr_t             sb_q[$];
  int              n_chk = 0;
  int              n_err = 0;
  int              wr_cnt = 0;
  logic [RAM_DATA_W-1:0] last_dina = '0;

  task automatic chk(input string tag, input logic [RAM_DATA_W-1:0] obs,
                     input logic [RAM_DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_lane(input logic [63:0] b);
`ifdef PCIE_WR_BYTESWAP_EN
    return {<<8{b}};
`else
    return b;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && bus.dma_wdata_busy; i++) step();
    chk("idle_wait", bus.dma_wdata_busy, 0);
  endtask

  task automatic send_addr(input logic [31:0] a);
    bus.dma_waddr    = a;
    bus.dma_waddr_en = 1'b1;
    step();
    bus.dma_waddr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    bus.dma_wdata    = d;
    bus.dma_wdata_en = 1'b1;
    step();
    bus.dma_wdata_en = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [63:0] seed);
    wr_t e;
    e.addr = a[ADDR_W+5:6];
    for (int k = 0; k < BEATS_PER_WORD; k++)
      e.data[RAM_DATA_W-1-64*k -: 64] = exp_lane(seed * 64'(k + 1));
    sb_q.push_back(e);
  endtask

  // One full transfer; beat k is seed*(k+1). Optionally pulses clear on the write cycle.
  task automatic xfer(input logic [31:0] a, input logic [63:0] seed, input int gap,
                      input bit clr_on_wr, input bit chk_busy);
    wait_idle();
    push_exp(a, seed);
    send_addr(a);
    if (chk_busy) chk("busy_after_addr", bus.dma_wdata_busy, 1);
    for (int k = 0; k < BEATS_PER_WORD; k++) begin
      send_beat(seed * 64'(k + 1));
      if (k < BEATS_PER_WORD - 1) repeat (gap) step();
    end
    if (chk_busy) chk("busy_in_write", bus.dma_wdata_busy, 1);
    if (clr_on_wr) bus.ts_ram_clear = 1'b1;
    step();
    bus.ts_ram_clear = 1'b0;
    if (chk_busy) chk("busy_fall", bus.dma_wdata_busy, 0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},  bus.dma_wdata_busy, 0);
    chk({pfx, "_wea"},   bus.ram_wea, 0);
    chk({pfx, "_addra"}, bus.ram_addra, 0);
    chk({pfx, "_dina"},  bus.ram_dina, 0);
    chk({pfx, "_valid"}, bus.ts_ram_valid, 0);
    chk({pfx, "_drop"},  bus.drop_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.ram_wea) begin
      wr_cnt++;
      last_dina = bus.ram_dina;
      if (sb_q.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", bus.ram_addra, e.addr);
        chk("wr_data", bus.ram_dina, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    logic [63:0] lane0;
    bus.dma_waddr_en = 1'b0;
    bus.dma_waddr    = '0;
    bus.dma_wdata_en = 1'b0;
    bus.dma_wdata    = '0;
    bus.ts_ram_clear = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Basic back-to-back write to word 1
    xfer(32'h40, 64'h1111_1111_1111_1111, 0, 1'b0, 1'b1);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_lane0", last_dina[511:448], 64'h1111_1111_1111_1111);
    chk("t1_lane7", last_dina[63:0], 64'h8888_8888_8888_8888);

    // Same transfer with 3 idle cycles between beats
    xfer(32'h40, 64'h1111_1111_1111_1111, 3, 1'b0, 1'b1);
    chk("t2_wr_cnt", wr_cnt, 2);

    // Beats with no address are dropped
    for (int i = 0; i < 4; i++) send_beat(64'hDEAD_0000 + 64'(i));
    chk("t3_drop4", bus.drop_cnt, 4);
    chk("t3_no_wr", wr_cnt, 2);

    // Address + beat together in IDLE: address taken, beat dropped
    push_exp(32'h100, 64'h0123_4567_89AB_CDEF);
    bus.dma_waddr    = 32'h100;
    bus.dma_waddr_en = 1'b1;
    bus.dma_wdata    = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.dma_wdata_en = 1'b1;
    step();
    bus.dma_waddr_en = 1'b0;
    bus.dma_wdata_en = 1'b0;
    chk("t3_drop_coincident", bus.drop_cnt, 5);
    for (int k = 0; k < 3; k++) send_beat(64'h0123_4567_89AB_CDEF * 64'(k + 1));
    send_addr(32'h80);
    chk("t3_busy_collect", bus.dma_wdata_busy, 1);
    for (int k = 3; k < 8; k++) send_beat(64'h0123_4567_89AB_CDEF * 64'(k + 1));
    send_beat(64'hBAD1_BAD1_BAD1_BAD1);
    chk("t3_drop_in_write", bus.drop_cnt, 6);
    chk("t3_wr_cnt", wr_cnt, 3);

    // Reset in the middle of collecting
    wait_idle();
    send_addr(32'h200);
    for (int k = 0; k < 5; k++) send_beat(64'h5555_0000_0000_0000 + 64'(k));
    rst_n = 1'b0;
    #2;
    chk_reset_vals("midrst");
    wc = wr_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("midrst_no_wr", wr_cnt, wc);

    // Frame of 64 words starting at word 2047; the first one also shows recovery after reset
    for (int i = 0; i < FRAME_WORDS; i++) begin
      xfer(32'h1FFC0 + 32'(64 * i), {$urandom, $urandom}, i % 2, 1'b0, 1'b0);
      if (i == 0) begin
        chk("post_rst_wr", wr_cnt, wc + 1);
        chk("wrap_addr_hi", bus.ram_addra, 11'd2047);
      end
      if (i == 1) chk("wrap_addr_lo", bus.ram_addra, 0);
      chk("frame_valid", bus.ts_ram_valid, (i == FRAME_WORDS - 1));
    end
    bus.ts_ram_clear = 1'b1;
    step();
    bus.ts_ram_clear = 1'b0;
    chk("valid_cleared", bus.ts_ram_valid, 0);

    // Second frame: clear pulsed on the frame-completing write, set wins
    for (int i = 0; i < FRAME_WORDS; i++) begin
      xfer(32'h1000 + 32'(64 * i), {$urandom, $urandom}, 0, (i == FRAME_WORDS - 1), 1'b0);
    end
    chk("set_beats_clear", bus.ts_ram_valid, 1);
    bus.ts_ram_clear = 1'b1;
    step();
    bus.ts_ram_clear = 1'b0;
    chk("valid_cleared2", bus.ts_ram_valid, 0);

    // Lane byte order of a recognisable beat
    xfer(32'h0, 64'h0102_0304_0506_0708, 0, 1'b0, 1'b0);
`ifdef PCIE_WR_BYTESWAP_EN
    lane0 = 64'h0807_0605_0403_0201;
`else
    lane0 = 64'h0102_0304_0506_0708;
`endif
    chk("lane0_order", last_dina[511:448], lane0);

    repeat (4) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
